// File: rtl/vram_planes_pkg.sv
// Shared types and helpers for the multi-plane video RAM.
package vram_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} cpu_state_e;

  localparam int PL_B = 0;
  localparam int PL_R = 1;
  localparam int PL_G = 2;

  // Isolates the lowest set bit of a mask (one-hot result, zero if none set).
  function automatic logic [31:0] lowest_set_bit(input logic [31:0] mask);
    return mask & (~mask + 32'd1);
  endfunction
endpackage

// File: rtl/vram_planes_if.sv
// CPU and CRT-fetch signal bundle for vram_planes.
interface vram_planes_if #(
  parameter int PLANES = 3,
  parameter int AW     = 14,
  parameter int DW     = 8
);
  logic                 CPU_REQ;
  logic                 CPU_WE;
  logic [AW-1:0]        CPU_ADRS;
  logic [PLANES-1:0]    CPU_PSEL;
  logic [DW-1:0]        CPU_DIN;
  logic                 CPU_ACK;
  logic [DW-1:0]        CPU_DOUT;
  logic                 VID_REQ;
  logic [AW-1:0]        VID_ADRS;
  logic                 VID_RDY;
  logic                 VID_VALID;
  logic [PLANES*DW-1:0] VID_DATA;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADRS, CPU_PSEL, CPU_DIN, VID_REQ, VID_ADRS,
    input  CPU_ACK, CPU_DOUT, VID_RDY, VID_VALID, VID_DATA
  );
  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADRS, CPU_PSEL, CPU_DIN, VID_REQ, VID_ADRS,
    output CPU_ACK, CPU_DOUT, VID_RDY, VID_VALID, VID_DATA
  );
endinterface

// File: rtl/ram.sv
// Generic synchronous single-port RAM, read-first, one-cycle registered read.
module ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;
endmodule

// File: rtl/vram_planes_arb.sv
// Per-cycle RAM arbiter: video normally wins, CPU wins once it has waited MAXWAIT cycles.
module vram_arb #(
  parameter int MAXWAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cpu_req,
  input  logic i_cpu_idle,
  input  logic i_vid_req,
  output logic o_grant_vid,
  output logic o_grant_cpu
);
  localparam int CW = $clog2(MAXWAIT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          w_cpu_pend;
  logic          w_starved;

  // A request only competes while the CPU FSM is idle; ACCESS/DONE are already served.
  assign w_cpu_pend  = i_cpu_req & i_cpu_idle;
  assign w_starved   = (r_wait_cnt == CW'(MAXWAIT));
  assign o_grant_vid = ~i_rst & i_vid_req & ~(w_cpu_pend & w_starved);
  assign o_grant_cpu = ~i_rst & w_cpu_pend & ~o_grant_vid;

  always_ff @(posedge i_clk) begin
    if (i_rst)                         r_wait_cnt <= '0;
    else if (o_grant_cpu)              r_wait_cnt <= '0;
    else if (w_cpu_pend && !w_starved) r_wait_cnt <= r_wait_cnt + CW'(1);
  end
endmodule

// File: rtl/vram_planes.sv
// Multi-plane video RAM: CPU req/ack port with broadcast write and priority read,
// plus a fully pipelined CRT fetch port returning every plane in parallel.
module vram_planes
  import vram_pkg::*;
#(
  parameter int PLANES  = 3,
  parameter int AW      = 14,
  parameter int DW      = 8,
  parameter int MAXWAIT = 4
) (
  input logic         CLKSYS,
  input logic         RESET,
  vram_planes_if.slave bus
);
  cpu_state_e           r_state, w_state_nxt;
  logic                 w_grant_vid, w_grant_cpu;
  logic [AW-1:0]        w_ram_addr;
  logic [PLANES-1:0]    w_we;
  logic [PLANES-1:0]    w_rd_mask;
  logic [DW-1:0]        w_q [PLANES];
  logic [PLANES*DW-1:0] w_vid_q;
  logic [DW-1:0]        w_rd_sel;
  logic [DW-1:0]        r_cpu_dout;
  logic                 r_vld_p1;
  logic [PLANES*DW-1:0] r_vid_hold;

  vram_arb #(.MAXWAIT(MAXWAIT)) u_arb (
    .i_clk       (CLKSYS),
    .i_rst       (RESET),
    .i_cpu_req   (bus.CPU_REQ),
    .i_cpu_idle  (r_state == IDLE),
    .i_vid_req   (bus.VID_REQ),
    .o_grant_vid (w_grant_vid),
    .o_grant_cpu (w_grant_cpu)
  );

  assign w_ram_addr = w_grant_vid ? bus.VID_ADRS : bus.CPU_ADRS;

  // Stage p0: shared address, write commits on the CPU grant cycle only.
  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    assign w_we[p] = w_grant_cpu & bus.CPU_WE & bus.CPU_PSEL[p];
    ram #(.AW(AW), .DW(DW)) u_ram (
      .i_clk  (CLKSYS),
      .i_we   (w_we[p]),
      .i_addr (w_ram_addr),
      .i_din  (bus.CPU_DIN),
      .o_dout (w_q[p])
    );
    assign w_vid_q[p*DW +: DW] = w_q[p];
  end

  assign w_rd_mask = PLANES'(lowest_set_bit(32'(bus.CPU_PSEL)));

  always_comb begin
    w_rd_sel = '0;
    for (int p = 0; p < PLANES; p++)
      if (w_rd_mask[p]) w_rd_sel = w_q[p];
  end

  always_ff @(posedge CLKSYS) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_cpu) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p1: RAM outputs valid; capture CPU read data and flag video data.
  always_ff @(posedge CLKSYS) begin
    if (RESET)                  r_cpu_dout <= '0;
    else if (r_state == ACCESS) r_cpu_dout <= bus.CPU_WE ? '0 : w_rd_sel;
  end

  always_ff @(posedge CLKSYS) begin
    if (RESET) begin
      r_vld_p1   <= 1'b0;
      r_vid_hold <= '0;
    end else begin
      r_vld_p1 <= w_grant_vid;
      if (r_vld_p1) r_vid_hold <= w_vid_q;
    end
  end

  assign bus.CPU_ACK   = (r_state == DONE);
  assign bus.CPU_DOUT  = r_cpu_dout;
  assign bus.VID_RDY   = w_grant_vid;
  assign bus.VID_VALID = r_vld_p1;
  assign bus.VID_DATA  = r_vld_p1 ? w_vid_q : r_vid_hold;

  a_req_held: assert property (@(posedge CLKSYS) disable iff (RESET)
    (r_state == ACCESS) |-> bus.CPU_REQ);
endmodule

// File: tb/tb_vram_planes.sv
// Randomised bench for vram_planes against a per-plane array model of the memory.
module tb_vram_planes;
  import vram_pkg::*;

  localparam int PLANES  = 3;
  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int MAXWAIT = 4;
  localparam int NPOOL   = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_planes_if #(.PLANES(PLANES), .AW(AW), .DW(DW)) bus ();
  vram_planes #(.PLANES(PLANES), .AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
    .CLKSYS(clk), .RESET(rst), .bus(bus));

  vram_planes_if #(.PLANES(4), .AW(10), .DW(16)) bus4 ();
  vram_planes #(.PLANES(4), .AW(10), .DW(16), .MAXWAIT(MAXWAIT)) dut4 (
    .CLKSYS(clk), .RESET(rst), .bus(bus4));

  int n_run = 0;
  int n_fail = 0;
  logic [DW-1:0] mdl [PLANES][2**AW];
  int pool [NPOOL];

  function automatic logic [PLANES*DW-1:0] exp_vid(input int a);
    logic [PLANES*DW-1:0] r;
    r = '0;
    for (int p = 0; p < PLANES; p++) r[p*DW +: DW] = mdl[p][a];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [PLANES-1:0] ps, input int a);
    logic [DW-1:0] r;
    r = '0;
    for (int p = PLANES - 1; p >= 0; p--) if (ps[p]) r = mdl[p][a];
    return r;
  endfunction

  // Drives one CPU access from an idle negedge; returns in the following idle cycle.
  task automatic cpu_op(input logic we, input int a, input logic [PLANES-1:0] ps,
                        input logic [DW-1:0] din, output logic [DW-1:0] dout, output int lat);
    bus.CPU_WE = we; bus.CPU_ADRS = a[AW-1:0]; bus.CPU_PSEL = ps; bus.CPU_DIN = din;
    bus.CPU_REQ = 1'b1;
    lat = -1; dout = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.CPU_ACK === 1'b1) begin lat = n; dout = bus.CPU_DOUT; break; end
    end
    bus.CPU_REQ = 1'b0;
    if (we) for (int p = 0; p < PLANES; p++) if (ps[p]) mdl[p][a] = din;
    @(negedge clk);
  endtask

  task automatic vid_fetch(input int a, output logic rdy, output logic vld,
                           output logic [PLANES*DW-1:0] d);
    bus.VID_REQ = 1'b1; bus.VID_ADRS = a[AW-1:0];
    #1 rdy = bus.VID_RDY;
    @(negedge clk);
    vld = bus.VID_VALID; d = bus.VID_DATA;
    bus.VID_REQ = 1'b0;
  endtask

  task automatic cpu_op4(input logic we, input logic [9:0] a, input logic [3:0] ps,
                         input logic [15:0] din, output logic [15:0] dout, output int lat);
    bus4.CPU_WE = we; bus4.CPU_ADRS = a; bus4.CPU_PSEL = ps; bus4.CPU_DIN = din;
    bus4.CPU_REQ = 1'b1;
    lat = -1; dout = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus4.CPU_ACK === 1'b1) begin lat = n; dout = bus4.CPU_DOUT; break; end
    end
    bus4.CPU_REQ = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.VID_REQ = 1'b1;
    repeat (3) @(negedge clk);
    n_run++; if (bus.VID_RDY !== 1'b0) begin n_fail++; $display("FAIL reset_vid_rdy got=%b exp=0", bus.VID_RDY); end
    n_run++; if (bus.VID_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid got=%b exp=0", bus.VID_VALID); end
    n_run++; if (bus.VID_DATA !== '0) begin n_fail++; $display("FAIL reset_vid_data got=%h exp=0", bus.VID_DATA); end
    n_run++; if (bus.CPU_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack got=%b exp=0", bus.CPU_ACK); end
    n_run++; if (bus.CPU_DOUT !== '0) begin n_fail++; $display("FAIL reset_cpu_dout got=%h exp=0", bus.CPU_DOUT); end
    bus.VID_REQ = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [DW-1:0] dout;
    logic [PLANES-1:0] ps;
    int lat;
    for (int i = 0; i < 16; i++) pool[i] = i;
    pool[16] = 'h0123; pool[17] = 'h0040; pool[18] = 2**AW - 1;
    for (int i = 0; i < NPOOL; i++)
      for (int p = 0; p < PLANES; p++) begin
        ps = '0; ps[p] = 1'b1;
        cpu_op(1'b1, pool[i], ps, DW'($urandom), dout, lat);
        n_run++; if (lat !== 2 || dout !== '0) begin n_fail++; $display("FAIL fill_write a=%h lat=%0d dout=%h exp lat=2 dout=0", pool[i], lat, dout); end
      end
  endtask

  task automatic test_broadcast();
    logic [DW-1:0] dout;
    logic [PLANES*DW-1:0] d;
    logic rdy, vld;
    int lat;
    cpu_op(1'b1, 'h0123, 3'b111, 8'h00, dout, lat);
    cpu_op(1'b1, 'h0123, 3'b101, 8'hA5, dout, lat);
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL bcast_latency got=%0d exp=2", lat); end
    n_run++; if (dout !== 8'h00) begin n_fail++; $display("FAIL bcast_dout got=%h exp=00", dout); end
    vid_fetch('h0123, rdy, vld, d);
    n_run++; if ({rdy, vld} !== 2'b11) begin n_fail++; $display("FAIL bcast_vid_hs got=%b%b exp=11", rdy, vld); end
    n_run++; if (d !== 24'hA500A5) begin n_fail++; $display("FAIL bcast_vid_data got=%h exp=a500a5", d); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] dout;
    logic [PLANES-1:0] ps;
    int lat;
    ps = '0; ps[PL_B] = 1'b1;
    cpu_op(1'b1, 'h3FFF, ps, 8'h11, dout, lat);
    ps = '0; ps[PL_R] = 1'b1;
    cpu_op(1'b1, 'h3FFF, ps, 8'h22, dout, lat);
    cpu_op(1'b0, 'h3FFF, 3'b110, 8'h00, dout, lat);
    n_run++; if (dout !== 8'h22 || lat !== 2) begin n_fail++; $display("FAIL prio_110 got=%h lat=%0d exp=22 lat=2", dout, lat); end
    cpu_op(1'b0, 'h3FFF, 3'b000, 8'h00, dout, lat);
    n_run++; if (dout !== 8'h00) begin n_fail++; $display("FAIL prio_000 got=%h exp=00", dout); end
    cpu_op(1'b0, 'h3FFF, 3'b111, 8'h00, dout, lat);
    n_run++; if (dout !== 8'h11) begin n_fail++; $display("FAIL prio_111 got=%h exp=11", dout); end
    cpu_op(1'b0, 'h3FFF, 3'b100, 8'h00, dout, lat);
    n_run++; if (dout !== mdl[PL_G]['h3FFF]) begin n_fail++; $display("FAIL prio_100 got=%h exp=%h", dout, mdl[PL_G]['h3FFF]); end
  endtask

  task automatic test_stream();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin bus.VID_REQ = 1'b1; bus.VID_ADRS = AW'(k); end
      else bus.VID_REQ = 1'b0;
      #1;
      if (k < 16) begin
        n_run++; if (bus.VID_RDY !== 1'b1) begin n_fail++; $display("FAIL stream_rdy k=%0d got=%b exp=1", k, bus.VID_RDY); end
      end
      if (k > 0) begin
        n_run++; if (bus.VID_VALID !== 1'b1 || bus.VID_DATA !== exp_vid(k - 1)) begin n_fail++; $display("FAIL stream_data a=%0d vld=%b got=%h exp=%h", k - 1, bus.VID_VALID, bus.VID_DATA, exp_vid(k - 1)); end
      end
      @(negedge clk);
    end
    n_run++; if (bus.VID_VALID !== 1'b0 || bus.VID_DATA !== exp_vid(15)) begin n_fail++; $display("FAIL stream_hold vld=%b got=%h exp=%h", bus.VID_VALID, bus.VID_DATA, exp_vid(15)); end
  endtask

  task automatic test_starvation();
    int ack_cyc;
    logic [DW-1:0] dout, exp_d;
    exp_d = mdl[PL_R][7];
    ack_cyc = -1; dout = '0;
    bus.VID_REQ = 1'b1; bus.VID_ADRS = AW'(5);
    bus.CPU_WE = 1'b0; bus.CPU_ADRS = AW'(7); bus.CPU_PSEL = 3'b010; bus.CPU_REQ = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_run++; if (bus.VID_RDY !== (c != MAXWAIT + 1)) begin n_fail++; $display("FAIL starve_rdy cyc=%0d got=%b exp=%b", c, bus.VID_RDY, c != MAXWAIT + 1); end
      if (c >= 2) begin
        n_run++; if (bus.VID_VALID !== (c != MAXWAIT + 2)) begin n_fail++; $display("FAIL starve_valid cyc=%0d got=%b exp=%b", c, bus.VID_VALID, c != MAXWAIT + 2); end
      end
      if (bus.CPU_ACK === 1'b1 && ack_cyc < 0) begin ack_cyc = c; dout = bus.CPU_DOUT; bus.CPU_REQ = 1'b0; end
      @(negedge clk);
    end
    bus.CPU_REQ = 1'b0; bus.VID_REQ = 1'b0;
    n_run++; if (ack_cyc !== MAXWAIT + 3) begin n_fail++; $display("FAIL starve_ack_cycle got=%0d exp=%0d", ack_cyc, MAXWAIT + 3); end
    n_run++; if (dout !== exp_d) begin n_fail++; $display("FAIL starve_dout got=%h exp=%h", dout, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] newd;
    logic [PLANES*DW-1:0] d;
    logic rdy, vld;
    int acks;
    // Reset while in ACCESS: the grant-cycle write already landed, but no ACK follows.
    newd = DW'($urandom);
    bus.CPU_WE = 1'b1; bus.CPU_ADRS = AW'('h40); bus.CPU_PSEL = 3'b111; bus.CPU_DIN = newd;
    bus.CPU_REQ = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.VID_REQ = 1'b1; bus.VID_ADRS = AW'('h40);
    @(negedge clk);
    #1;
    n_run++; if (bus.CPU_ACK !== 1'b0 || bus.CPU_DOUT !== '0) begin n_fail++; $display("FAIL abort_cpu ack=%b dout=%h exp=0 0", bus.CPU_ACK, bus.CPU_DOUT); end
    n_run++; if ({bus.VID_RDY, bus.VID_VALID} !== 2'b00 || bus.VID_DATA !== '0) begin n_fail++; $display("FAIL abort_vid rdy=%b vld=%b data=%h exp=0", bus.VID_RDY, bus.VID_VALID, bus.VID_DATA); end
    rst = 1'b0; bus.CPU_REQ = 1'b0; bus.VID_REQ = 1'b0;
    for (int p = 0; p < PLANES; p++) mdl[p]['h40] = newd;
    acks = 0;
    repeat (4) begin @(negedge clk); if (bus.CPU_ACK === 1'b1) acks++; end
    n_run++; if (acks !== 0) begin n_fail++; $display("FAIL abort_late_ack got=%0d exp=0", acks); end
    vid_fetch('h40, rdy, vld, d);
    n_run++; if (d !== exp_vid('h40)) begin n_fail++; $display("FAIL abort_committed got=%h exp=%h", d, exp_vid('h40)); end
    // Reset during the grant cycle: the write must not reach any plane.
    bus.CPU_DIN = ~newd; bus.CPU_REQ = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.CPU_REQ = 1'b0;
    acks = 0;
    repeat (3) begin @(negedge clk); if (bus.CPU_ACK === 1'b1) acks++; end
    n_run++; if (acks !== 0) begin n_fail++; $display("FAIL abort_grant_ack got=%0d exp=0", acks); end
    vid_fetch('h40, rdy, vld, d);
    n_run++; if (d !== exp_vid('h40)) begin n_fail++; $display("FAIL abort_dropped got=%h exp=%h", d, exp_vid('h40)); end
  endtask

  task automatic test_random();
    logic [DW-1:0] dout, exp_d, din;
    logic [PLANES*DW-1:0] d;
    logic [PLANES-1:0] ps;
    logic rdy, vld;
    int a, kind, lat;
    repeat (60) begin
      a = pool[$urandom_range(0, NPOOL - 1)];
      kind = $urandom_range(0, 2);
      ps = PLANES'($urandom); din = DW'($urandom);
      if (kind == 2) begin
        vid_fetch(a, rdy, vld, d);
        n_run++; if ({rdy, vld} !== 2'b11 || d !== exp_vid(a)) begin n_fail++; $display("FAIL rand_vid a=%h rdy=%b vld=%b got=%h exp=%h", a, rdy, vld, d, exp_vid(a)); end
      end else begin
        exp_d = (kind == 1) ? exp_rd(ps, a) : '0;
        cpu_op(kind == 0, a, ps, din, dout, lat);
        n_run++; if (lat !== 2 || dout !== exp_d) begin n_fail++; $display("FAIL rand_cpu we=%0d a=%h ps=%b lat=%0d got=%h exp=%h", kind == 0, a, ps, lat, dout, exp_d); end
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] dout;
    logic [3:0] rps [4];
    logic [15:0] rexp [4];
    int lat;
    rps = '{4'b1100, 4'b1000, 4'b0110, 4'b0000};
    rexp = '{16'h3333, 16'hBEEF, 16'hBEEF, 16'h0000};
    cpu_op4(1'b1, 10'h3FF, 4'b0001, 16'h1111, dout, lat);
    cpu_op4(1'b1, 10'h3FF, 4'b0010, 16'h2222, dout, lat);
    cpu_op4(1'b1, 10'h3FF, 4'b0100, 16'h3333, dout, lat);
    cpu_op4(1'b1, 10'h3FF, 4'b1000, 16'h4444, dout, lat);
    cpu_op4(1'b1, 10'h3FF, 4'b1010, 16'hBEEF, dout, lat);
    n_run++; if (lat !== 2 || dout !== 16'h0) begin n_fail++; $display("FAIL p4_bcast lat=%0d dout=%h exp lat=2 dout=0", lat, dout); end
    bus4.VID_REQ = 1'b1; bus4.VID_ADRS = 10'h3FF;
    #1;
    n_run++; if (bus4.VID_RDY !== 1'b1) begin n_fail++; $display("FAIL p4_vid_rdy got=%b exp=1", bus4.VID_RDY); end
    @(negedge clk);
    n_run++; if (bus4.VID_VALID !== 1'b1 || bus4.VID_DATA !== 64'hBEEF_3333_BEEF_1111) begin n_fail++; $display("FAIL p4_vid_data vld=%b got=%h exp=beef3333beef1111", bus4.VID_VALID, bus4.VID_DATA); end
    n_run++; if (bus4.VID_DATA[63:48] !== 16'hBEEF) begin n_fail++; $display("FAIL p4_plane3 got=%h exp=beef", bus4.VID_DATA[63:48]); end
    bus4.VID_REQ = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cpu_op4(1'b0, 10'h3FF, rps[i], 16'h0, dout, lat);
      n_run++; if (lat !== 2 || dout !== rexp[i]) begin n_fail++; $display("FAIL p4_read ps=%b lat=%0d got=%h exp=%h", rps[i], lat, dout, rexp[i]); end
    end
  endtask

  initial begin
    bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADRS = '0; bus.CPU_PSEL = '0;
    bus.CPU_DIN = '0; bus.VID_REQ = 1'b0; bus.VID_ADRS = '0;
    bus4.CPU_REQ = 1'b0; bus4.CPU_WE = 1'b0; bus4.CPU_ADRS = '0; bus4.CPU_PSEL = '0;
    bus4.CPU_DIN = '0; bus4.VID_REQ = 1'b0; bus4.VID_ADRS = '0;
    test_reset();
    test_fill();
    test_broadcast();
    test_priority();
    test_stream();
    test_starvation();
    test_reset_abort();
    test_random();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
